// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for the EX stage.
// One quotient bit per cycle; holds the result until the pipeline advances.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  input  logic             i_cancel,
  input  logic             i_advance,
  output logic             o_div_stall,
  output logic             o_busy,
  output logic             o_result_valid,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_opb_zero;
  logic             w_last;

  // Operand magnitudes and one restoring step; the borrow of the WIDTH+1 subtract is rem < div.
  always_comb begin
    w_mag_a    = (i_is_signed & i_opa[WIDTH-1]) ? (~i_opa + 1'b1) : i_opa;
    w_mag_b    = (i_is_signed & i_opb[WIDTH-1]) ? (~i_opb + 1'b1) : i_opb;
    w_opb_zero = (i_opb == '0);
    w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_rem_sh - {1'b0, r_div};
    w_ge       = ~w_diff[WIDTH];
    w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    w_last     = (r_cnt == LastCnt);
  end

  // Next-state logic; cancel overrides every other transition.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = w_opb_zero ? StDone : StBusy;
      StBusy:  if (w_last) w_state_d = StDone;
      StDone:  if (i_advance) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (i_cancel) w_state_d = StIdle;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= StIdle;
    else           r_state <= w_state_d;
  end

  // Datapath: operand capture, iteration, sign fix-up; frozen on cancel so hi/lo keep old value.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (!i_cancel) begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_div   <= w_mag_b;
            r_neg_q <= i_is_signed & (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
            r_neg_r <= i_is_signed & i_opa[WIDTH-1];
            if (w_opb_zero) begin
              r_hi <= i_opa;
              r_lo <= '1;
            end
          end
        end
        StBusy: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi <= r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
            r_lo <= r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs; stall is combinational so the pipeline moves on the first DONE cycle.
  always_comb begin
    o_div_stall    = ~i_cancel & (((r_state == StIdle) & i_start) | (r_state == StBusy));
    o_busy         = (r_state == StBusy);
    o_result_valid = (r_state == StDone);
    o_hi           = r_hi;
    o_lo           = r_lo;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a result scoreboard.
module tb_div_ctrl;

  localparam int unsigned W = 32;

  logic         clk;
  logic         resetn;
  logic         start;
  logic         is_signed;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         cancel;
  logic         advance;
  logic         div_stall;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] sb[$];
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  div_ctrl #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_start        (start),
    .i_is_signed    (is_signed),
    .i_opa          (opa),
    .i_opb          (opb),
    .i_cancel       (cancel),
    .i_advance      (advance),
    .o_div_stall    (div_stall),
    .o_busy         (busy),
    .o_result_valid (result_valid),
    .o_hi           (hi),
    .o_lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {remainder, quotient} from plain integer division on magnitudes.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg);
    logic [W-1:0] ma, mb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    ma = (sg && a[W-1]) ? -a : a;
    mb = (sg && b[W-1]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sg && (a[W-1] ^ b[W-1])) q = -q;
    if (sg && a[W-1]) r = -r;
    return {r, q};
  endfunction

  // Issue one divide, measure stall length, compare the result, optionally hold in DONE.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input logic [2*W-1:0] exp, input int hold, input logic keep_start);
    int n;
    logic [2*W-1:0] e;
    sb.push_back(exp);
    start = 1'b1; is_signed = sg; opa = a; opb = b; advance = 1'b0;
    #1;
    n = 0;
    while (div_stall === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("stall_cycles", 64'(n), (b == '0) ? 64'd1 : 64'(W + 1));
    check("done_valid", 64'(result_valid), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check("hi", 64'(hi), 64'(e[2*W-1:W]));
    check("lo", 64'(lo), 64'(e[W-1:0]));
    if (!keep_start) start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_stall", 64'(div_stall), 64'd0);
      check("hold_valid", 64'(result_valid), 64'd1);
      check("hold_hi", 64'(hi), 64'(e[2*W-1:W]));
      check("hold_lo", 64'(lo), 64'(e[W-1:0]));
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    #1;
    check("adv_idle", 64'(result_valid), 64'd0);
    if (keep_start) check("restart_stall", 64'(div_stall), 64'd1);
    last_hi = e[2*W-1:W];
    last_lo = e[W-1:0];
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    resetn = 1'b0; start = 1'b0; is_signed = 1'b0; opa = '0; opb = '0;
    cancel = 1'b0; advance = 1'b0;
    tick();
    tick();
    check("rst_stall", 64'(div_stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    resetn = 1'b1;
    tick();

    // Directed results
    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 0, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 0, 1'b0);
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0, 1'b0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 0, 1'b0);

    // Mixed-pattern divides against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      run_div(ra, rb, i[0], model(ra, rb, i[0]), 0, 1'b0);
    end

    // Cancel at BUSY cycle 10
    start = 1'b1; is_signed = 1'b0; opa = 32'd1000; opb = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    check("pre_cancel_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    #1;
    check("cancel_stall", 64'(div_stall), 64'd0);
    tick();
    cancel = 1'b0; start = 1'b0;
    #1;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_valid", 64'(result_valid), 64'd0);
    check("cancel_hi_kept", 64'(hi), 64'(last_hi));
    check("cancel_lo_kept", 64'(lo), 64'(last_lo));
    tick();
    check("cancel_valid2", 64'(result_valid), 64'd0);
    run_div(32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 0, 1'b0);

    // Hold in DONE with start high, then advance and immediate restart
    run_div(32'd81, 32'd9, 1'b0, {32'd0, 32'd9}, 4, 1'b1);
    run_div(32'd82, 32'd9, 1'b0, {32'd1, 32'd9}, 0, 1'b0);

    // Asynchronous reset at BUSY cycle 20
    start = 1'b1; is_signed = 1'b1; opa = 32'hFFFF_FF00; opb = 32'd16;
    for (int i = 0; i < 20; i++) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    resetn = 1'b0; start = 1'b0;
    #1;
    check("mid_rst_stall", 64'(div_stall), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(result_valid), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    run_div(32'hFFFF_FF00, 32'd16, 1'b1, {32'd0, 32'hFFFF_FFF0}, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
